partsel_accum_ctrl: RTL and testbench
=====================================

PARTSEL_ACCUM_CTRL -- requirements
Module: partsel_accum_ctrl

Interface
REQ-001 SHALL have parameter NWORDS, default 2, number of packed words in the bank.
REQ-002 SHALL have parameter WIDTH, default 32, bits per word and accumulator width.
REQ-003 SHALL have parameter FIELD, default 8, width of each indexed part-select (idx+:FIELD).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  1  bank word write strobe.
REQ-007 SHALL have port wr_sel  input  $clog2(NWORDS)  bank word to write.
REQ-008 SHALL have port wr_data  input  WIDTH  bank write data.
REQ-009 SHALL have port req_valid  input  1  request offered.
REQ-010 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-011 SHALL have port req_sel  input  $clog2(NWORDS)  bank word to scan.
REQ-012 SHALL have port req_start  input  8  signed first bit index.
REQ-013 SHALL have port req_count  input  5  number of steps, 0..31.
REQ-014 SHALL have port rsp_valid  output  1  result available.
REQ-015 SHALL have port rsp_ready  input  1  result consumed when high with rsp_valid.
REQ-016 SHALL have port rsp_acc  output  WIDTH  accumulated sum.
REQ-017 SHALL have port rsp_oob  output  1  at least one step touched bits outside [0,WIDTH-1].

Function
REQ-018 SHALL implement FSM IDLE, RUN, DONE; req_ready = (state==IDLE) and not rst.
REQ-019 SHALL on accept in IDLE latch sel, start, count; clear acc and oob; go to RUN if count!=0, else DONE.
REQ-020 SHALL in RUN, per cycle, add field(idx) to acc, idx+=1, remaining-=1; leave for DONE on the step with remaining==1.
REQ-021 SHALL define field(idx) bit k = bank[sel][idx+k] for idx+k in [0,WIDTH-1], else 0; zero-extended to WIDTH.
REQ-022 SHALL hold idx in at least 10 signed bits so start+count never wraps.
REQ-023 SHALL set oob if any step has idx<0 or idx+FIELD-1>WIDTH-1.
REQ-024 SHALL wrap acc modulo 2^WIDTH.
REQ-025 SHALL assert rsp_valid only in DONE: count cycles after accept edge for count>=1, one cycle for count=0.
REQ-026 SHALL hold rsp_valid, rsp_acc, rsp_oob stable in DONE until rsp_ready; then IDLE next cycle.
REQ-027 SHALL apply bank writes at any state; a step in the same cycle as a write to its word reads the pre-write value.
REQ-028 SHALL ignore req_valid outside IDLE.

Reset
REQ-029 SHALL on rst: state IDLE, bank all zero, acc 0, oob 0, rsp_valid 0, req_ready 0 during rst, 1 the cycle after.
REQ-030 SHALL abandon an in-flight RUN or DONE on rst without producing a response.

Configuration
REQ-031 SHALL with PARTSEL_ACCUM_SIGNED_EN defined sign-extend field(idx) from bit FIELD-1 before adding; without it zero-extend.

Verification
REQ-032 SHALL cover: bank[1]=32'hFFFFFFFF, sel=1 start=-10 count=20 -> rsp_acc=32'h00000FF8, rsp_oob=1, rsp_valid 20 cycles after accept.
REQ-033 SHALL cover: bank[0]=32'h12345678, sel=0 start=24 count=1 -> rsp_acc=32'h12, rsp_oob=0, rsp_valid 1 cycle after accept.
REQ-034 SHALL cover: count=0 -> rsp_acc=0, rsp_oob=0, rsp_valid 1 cycle after accept.
REQ-035 SHALL cover: rsp_ready low 5 cycles in DONE -> outputs stable, req_ready=0; after handshake req_ready=1 next cycle.
REQ-036 SHALL cover: rst asserted 3 steps into RUN -> next cycle IDLE, rsp_valid=0, bank reads zero on following request.
REQ-037 SHALL cover: bank[0]=32'hFFFFFFFF, start=0 count=1 -> rsp_acc=32'hFF without macro, 32'hFFFFFFFF with PARTSEL_ACCUM_SIGNED_EN.

Source files
------------

// File: rtl/partsel_accum_ctrl.sv
// partsel_accum_ctrl: scans idx+:FIELD windows of a banked word and accumulates them.
// Define PARTSEL_ACCUM_SIGNED_EN to sign-extend each field before adding (default zero-extends).
module partsel_accum_ctrl #(
  parameter int NWORDS = 2,
  parameter int WIDTH  = 32,
  parameter int FIELD  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [$clog2(NWORDS)-1:0] wr_sel,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [$clog2(NWORDS)-1:0] req_sel,
  input  logic [7:0]                req_start,
  input  logic [4:0]                req_count,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [WIDTH-1:0]          rsp_acc,
  output logic                      rsp_oob
);
  localparam int SW = $clog2(NWORDS);
  localparam int PW = $clog2(WIDTH);
  localparam int IW = 16;
  localparam logic signed [IW-1:0] WLIM = IW'(WIDTH);
  localparam logic signed [IW-1:0] OLIM = IW'(WIDTH - FIELD);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       bank_q [NWORDS];
  logic [SW-1:0]          sel_q, sel_d;
  logic signed [IW-1:0]   idx_q, idx_d;
  logic [4:0]             rem_q, rem_d;
  logic [WIDTH-1:0]       acc_q, acc_d;
  logic                   oob_q, oob_d;
  logic [WIDTH-1:0]       word;
  logic [FIELD-1:0]       fld;
  logic [WIDTH-1:0]       ext;
  logic signed [IW-1:0]   pos;
  logic                   step_oob;
  logic                   accept;
  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign word      = bank_q[sel_q];
  assign rsp_valid = state_q == DONE;
  assign rsp_acc   = acc_q;
  assign rsp_oob   = oob_q;
  assign step_oob  = idx_q[IW-1] || (idx_q > OLIM);
  // Bits that fall outside the word read as zero.
  always_comb begin
    fld = '0;
    pos = '0;
    for (int k = 0; k < FIELD; k++) begin
      pos = idx_q + IW'(k);
      if (!pos[IW-1] && pos < WLIM) fld[k] = word[pos[PW-1:0]];
    end
  end
`ifdef PARTSEL_ACCUM_SIGNED_EN
  assign ext = {{(WIDTH-FIELD){fld[FIELD-1]}}, fld};
`else
  assign ext = {{(WIDTH-FIELD){1'b0}}, fld};
`endif
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    oob_d   = oob_q;
    if (accept) begin
      sel_d   = req_sel;
      idx_d   = IW'($signed(req_start));
      rem_d   = req_count;
      acc_d   = '0;
      oob_d   = 1'b0;
      state_d = (req_count != 5'd0) ? RUN : DONE;
    end else if (state_q == RUN) begin
      acc_d   = acc_q + ext;
      oob_d   = oob_q | step_oob;
      idx_d   = idx_q + IW'(1);
      rem_d   = rem_q - 5'd1;
      state_d = (rem_q == 5'd1) ? DONE : RUN;
    end else if (state_q == DONE && rsp_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      oob_q   <= 1'b0;
      for (int i = 0; i < NWORDS; i++) bank_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      oob_q   <= oob_d;
      if (wr_en) bank_q[wr_sel] <= wr_data;
    end
  end
endmodule

// File: tb/tb_partsel_accum_ctrl.sv
// tb_partsel_accum_ctrl: directed requests with a queued-expectation monitor.
module tb_partsel_accum_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [0:0]  wr_sel = '0;
  logic [31:0] wr_data = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [0:0]  req_sel = '0;
  logic [7:0]  req_start = '0;
  logic [4:0]  req_count = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_acc;
  logic        rsp_oob;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic prev_valid = 1'b0;
  typedef struct {logic [31:0] acc; logic oob; int lat;} exp_t;
  exp_t q[$];
`ifdef PARTSEL_ACCUM_SIGNED_EN
  localparam logic [31:0] E_SPAN = 32'hFFFFFEF8;
  localparam logic [31:0] E_FF   = 32'hFFFFFFFF;
`else
  localparam logic [31:0] E_SPAN = 32'h00000FF8;
  localparam logic [31:0] E_FF   = 32'h000000FF;
`endif
  partsel_accum_ctrl dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_start(req_start), .req_count(req_count), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_acc(rsp_acc), .rsp_oob(rsp_oob)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask
  // Response monitor: latency on first sighting, value stability every cycle held.
  always @(negedge clk) begin
    if (req_valid && req_ready) acc_cyc = cyc;
    if (rsp_valid) begin
      if (q.size() == 0) check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      else begin
        if (!prev_valid) check("latency", 32'(cyc - acc_cyc - 1), 32'(q[0].lat));
        check("acc", rsp_acc, q[0].acc);
        check("oob", 32'(rsp_oob), 32'(q[0].oob));
        check("ready_in_done", 32'(req_ready), 32'd0);
        if (rsp_ready) void'(q.pop_front());
      end
    end
    prev_valid = rsp_valid;
  end
  task automatic wr(input logic s, input logic [31:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_sel = s; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask
  task automatic do_req(input logic s, input int start, input int cnt,
                        input logic [31:0] ea, input logic eo, input bit push);
    @(posedge clk); #1;
    req_valid = 1'b1; req_sel = s; req_start = 8'(start); req_count = 5'(cnt);
    if (push) q.push_back(exp_t'{ea, eo, cnt});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || !req_ready) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) check("idle_timeout", 32'(q.size()), 32'd0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("ready_in_rst", 32'(req_ready), 32'd0);
    check("valid_in_rst", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(req_ready), 32'd1);
    // Span across the low edge, with requests offered mid-run that must be ignored.
    wr(1'b1, 32'hFFFFFFFF);
    do_req(1'b1, -10, 20, E_SPAN, 1'b1, 1'b1);
    req_valid = 1'b1; req_start = 8'd0; req_count = 5'd0;
    repeat (3) @(posedge clk);
    #1 req_valid = 1'b0;
    wait_idle();
    wr(1'b0, 32'h12345678);
    do_req(1'b0, 24, 1, 32'h12, 1'b0, 1'b1);
    wait_idle();
    do_req(1'b0, 5, 0, 32'h0, 1'b0, 1'b1);
    wait_idle();
    do_req(1'b0, 26, 2, 32'h6, 1'b1, 1'b1);
    wait_idle();
    // Backpressure: hold the result five cycles.
    rsp_ready = 1'b0;
    do_req(1'b1, 0, 1, E_FF, 1'b0, 1'b1);
    begin
      int n = 0;
      while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
      check("hold_valid_seen", 32'(rsp_valid), 32'd1);
    end
    repeat (5) @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("ready_after_hs", 32'(req_ready), 32'd1);
    check("valid_after_hs", 32'(rsp_valid), 32'd0);
    wait_idle();
    wr(1'b0, 32'hFFFFFFFF);
    do_req(1'b0, 0, 1, E_FF, 1'b0, 1'b1);
    wait_idle();
    // First step coincides with a write to the scanned word: it must see the old value.
    wr(1'b0, 32'h000000FF);
    @(posedge clk); #1;
    req_valid = 1'b1; req_sel = 1'b0; req_start = 8'd0; req_count = 5'd2;
    q.push_back(exp_t'{E_FF, 1'b0, 2});
    @(posedge clk); #1;
    req_valid = 1'b0; wr_en = 1'b1; wr_sel = 1'b0; wr_data = 32'h0;
    @(posedge clk); #1;
    wr_en = 1'b0;
    wait_idle();
    // Reset three steps into a run: no response, bank cleared.
    wr(1'b1, 32'hFFFFFFFF);
    do_req(1'b1, 0, 10, 32'h0, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("ready_during_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    check("valid_after_rst", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("ready_after_rst2", 32'(req_ready), 32'd1);
    check("valid_after_rst2", 32'(rsp_valid), 32'd0);
    do_req(1'b1, 0, 1, 32'h0, 1'b0, 1'b1);
    wait_idle();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
